// File: rtl/mesi_cache_ctrl.sv
// Direct-mapped write-back L1 data cache controller with MESI snooping, one word per line.
// Optional hit/miss counters are built when MESI_CACHE_STATS_EN is defined.
module mesi_cache_ctrl #(
  parameter int TAG_W    = 14,
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 2,
  parameter int ADDR_W   = TAG_W + INDEX_W + OFFSET_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       DataFromProc,
  output logic [31:0]       DataToProc,
  output logic              Ready,
  output logic              BusReq,
  output logic [1:0]        BusCmd,
  output logic [ADDR_W-1:0] BusAddr,
  output logic [31:0]       DataOut,
  input  logic [31:0]       DataIn,
  input  logic              BusAck,
  input  logic              Shared,
  input  logic              SnoopValid,
  input  logic [1:0]        SnoopCmd,
  input  logic [ADDR_W-1:0] SnoopAddr,
  output logic              SharedOut,
  output logic              Flush
`ifdef MESI_CACHE_STATS_EN
  ,
  output logic [15:0]       HitCount,
  output logic [15:0]       MissCount
`endif
);

  // state | meaning
  // IDLE  | waiting for a processor request
  // WB    | writing back a Modified victim
  // FILL  | fetching the line with BusRd / BusRdX
  // UPGR  | BusUpgr to gain ownership of a Shared line
  // RESP  | Ready pulse to the processor

  localparam int LINES = 1 << INDEX_W;

  localparam logic [1:0] MESI_I = 2'd0;
  localparam logic [1:0] MESI_S = 2'd1;
  localparam logic [1:0] MESI_E = 2'd2;
  localparam logic [1:0] MESI_M = 2'd3;

  localparam logic [1:0] CMD_RD   = 2'd0;
  localparam logic [1:0] CMD_RDX  = 2'd1;
  localparam logic [1:0] CMD_UPGR = 2'd2;
  localparam logic [1:0] CMD_WB   = 2'd3;

  typedef enum logic [2:0] {ST_IDLE, ST_WB, ST_FILL, ST_UPGR, ST_RESP} state_t;

  state_t            r_state;
  logic [1:0]        r_mesi [LINES];
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [31:0]       r_data [LINES];

  logic [31:0]       r_data_to_proc;
  logic              r_ready;
  logic              r_bus_req;
  logic [1:0]        r_bus_cmd;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [31:0]       r_data_out;
  logic              r_op_wr;

  logic [TAG_W-1:0]   w_req_tag;
  logic [INDEX_W-1:0] w_req_idx;
  logic               w_req_valid;
  logic               w_req_wr;
  logic [1:0]         w_line_st;
  logic               w_hit;
  logic [ADDR_W-1:0]  w_line_addr;
  logic [ADDR_W-1:0]  w_victim_addr;

  logic [TAG_W-1:0]   w_snp_tag;
  logic [INDEX_W-1:0] w_snp_idx;
  logic [1:0]         w_snp_st;
  logic               w_snoop_hit;
  logic               w_snp_kill;
  logic               w_flush;
  logic               w_unused_bits;

  assign w_req_tag     = address[ADDR_W-1 -: TAG_W];
  assign w_req_idx     = address[OFFSET_W +: INDEX_W];
  assign w_req_valid   = READ | WRITE;
  assign w_req_wr      = WRITE & ~READ;
  assign w_line_st     = r_mesi[w_req_idx];
  assign w_hit         = (w_line_st != MESI_I) && (r_tag[w_req_idx] == w_req_tag);
  assign w_line_addr   = {w_req_tag, w_req_idx, {OFFSET_W{1'b0}}};
  assign w_victim_addr = {r_tag[w_req_idx], w_req_idx, {OFFSET_W{1'b0}}};

  assign w_snp_tag   = SnoopAddr[ADDR_W-1 -: TAG_W];
  assign w_snp_idx   = SnoopAddr[OFFSET_W +: INDEX_W];
  assign w_snp_st    = r_mesi[w_snp_idx];
  assign w_snoop_hit = SnoopValid && (w_snp_st != MESI_I) && (r_tag[w_snp_idx] == w_snp_tag);
  assign w_snp_kill  = w_snoop_hit && ((SnoopCmd == CMD_RDX) || (SnoopCmd == CMD_UPGR));
  assign w_flush     = w_snoop_hit && (w_snp_st == MESI_M) &&
                       ((SnoopCmd == CMD_RD) || (SnoopCmd == CMD_RDX));

  assign w_unused_bits = ^{address[OFFSET_W-1:0], SnoopAddr[OFFSET_W-1:0]};

  assign DataToProc = r_data_to_proc;
  assign Ready      = r_ready;
  assign BusReq     = r_bus_req;
  assign BusCmd     = r_bus_cmd;
  assign BusAddr    = r_bus_addr;
  assign SharedOut  = w_snoop_hit;
  assign Flush      = w_flush;
  // A flush borrows the data bus in the snoop cycle; otherwise show the writeback word.
  assign DataOut    = w_flush ? r_data[w_snp_idx] : r_data_out;

`ifdef MESI_CACHE_STATS_EN
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;
  assign HitCount  = r_hit_cnt;
  assign MissCount = r_miss_cnt;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_data_to_proc <= '0;
      r_ready        <= 1'b0;
      r_bus_req      <= 1'b0;
      r_bus_cmd      <= CMD_RD;
      r_bus_addr     <= '0;
      r_data_out     <= '0;
      r_op_wr        <= 1'b0;
      for (int i = 0; i < LINES; i++) begin
        r_mesi[i] <= MESI_I;
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
`ifdef MESI_CACHE_STATS_EN
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Hold off a request while a snoop is updating line state this cycle.
          if (w_req_valid && !w_snoop_hit) begin
            r_op_wr <= w_req_wr;
`ifdef MESI_CACHE_STATS_EN
            if (w_hit) begin
              if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
            end else begin
              if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
            end
`endif
            if (w_hit) begin
              if (!w_req_wr) begin
                r_data_to_proc <= r_data[w_req_idx];
                r_ready        <= 1'b1;
                r_state        <= ST_RESP;
              end else if (w_line_st == MESI_S) begin
                r_bus_req  <= 1'b1;
                r_bus_cmd  <= CMD_UPGR;
                r_bus_addr <= w_line_addr;
                r_state    <= ST_UPGR;
              end else begin
                r_data[w_req_idx] <= DataFromProc;
                r_mesi[w_req_idx] <= MESI_M;
                r_ready           <= 1'b1;
                r_state           <= ST_RESP;
              end
            end else if (w_line_st == MESI_M) begin
              r_bus_req  <= 1'b1;
              r_bus_cmd  <= CMD_WB;
              r_bus_addr <= w_victim_addr;
              r_data_out <= r_data[w_req_idx];
              r_state    <= ST_WB;
            end else begin
              r_bus_req  <= 1'b1;
              r_bus_cmd  <= w_req_wr ? CMD_RDX : CMD_RD;
              r_bus_addr <= w_line_addr;
              r_state    <= ST_FILL;
            end
          end
        end

        ST_WB: begin
          if (BusAck) begin
            r_bus_req         <= 1'b0;
            r_mesi[w_req_idx] <= MESI_I;
            r_state           <= ST_FILL;
          end
        end

        ST_FILL: begin
          if (!r_bus_req) begin
            r_bus_req  <= 1'b1;
            r_bus_cmd  <= r_op_wr ? CMD_RDX : CMD_RD;
            r_bus_addr <= w_line_addr;
          end else if (BusAck) begin
            r_bus_req        <= 1'b0;
            r_tag[w_req_idx] <= w_req_tag;
            if (r_op_wr) begin
              r_data[w_req_idx] <= DataFromProc;
              r_mesi[w_req_idx] <= MESI_M;
            end else begin
              r_data[w_req_idx] <= DataIn;
              r_mesi[w_req_idx] <= Shared ? MESI_S : MESI_E;
              r_data_to_proc    <= DataIn;
            end
            r_ready <= 1'b1;
            r_state <= ST_RESP;
          end
        end

        ST_UPGR: begin
          if (BusAck) begin
            r_bus_req         <= 1'b0;
            r_data[w_req_idx] <= DataFromProc;
            r_mesi[w_req_idx] <= MESI_M;
            r_ready           <= 1'b1;
            r_state           <= ST_RESP;
          end else if (w_snp_kill && (w_snp_idx == w_req_idx)) begin
            // Our Shared copy was just invalidated, so ownership now needs a full BusRdX.
            r_bus_cmd <= CMD_RDX;
            r_state   <= ST_FILL;
          end
        end

        ST_RESP: begin
          r_ready <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase

      if (w_snoop_hit) begin
        case (SnoopCmd)
          CMD_RD:            r_mesi[w_snp_idx] <= MESI_S;
          CMD_RDX, CMD_UPGR: r_mesi[w_snp_idx] <= MESI_I;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mesi_cache_ctrl.sv
// Directed self-checking bench for mesi_cache_ctrl with a simple auto-acking bus responder.
module tb_mesi_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        READ = 1'b0, WRITE = 1'b0;
  logic [19:0] address = '0;
  logic [31:0] DataFromProc = '0;
  logic [31:0] DataToProc;
  logic        Ready;
  logic        BusReq;
  logic [1:0]  BusCmd;
  logic [19:0] BusAddr;
  logic [31:0] DataOut;
  logic [31:0] DataIn = '0;
  logic        BusAck = 1'b0;
  logic        Shared = 1'b0;
  logic        SnoopValid = 1'b0;
  logic [1:0]  SnoopCmd = '0;
  logic [19:0] SnoopAddr = '0;
  logic        SharedOut;
  logic        Flush;

  int checks = 0;
  int errors = 0;

  mesi_cache_ctrl dut (
    .clock(clk), .reset(rst_n), .READ(READ), .WRITE(WRITE), .address(address),
    .DataFromProc(DataFromProc), .DataToProc(DataToProc), .Ready(Ready),
    .BusReq(BusReq), .BusCmd(BusCmd), .BusAddr(BusAddr), .DataOut(DataOut),
    .DataIn(DataIn), .BusAck(BusAck), .Shared(Shared), .SnoopValid(SnoopValid),
    .SnoopCmd(SnoopCmd), .SnoopAddr(SnoopAddr), .SharedOut(SharedOut), .Flush(Flush)
  );

  always #5 clk = ~clk;

  // {TAG, INDEX, BYTESELECT}: A = tag 2/idx 0/bs 1, B = tag 3/idx 0, C = tag 7/idx 1, X = tag 5/idx 0
  localparam logic [19:0] ADDR_A = 20'h00081;
  localparam logic [19:0] WORD_A = 20'h00080;
  localparam logic [19:0] ADDR_B = 20'h000C0;
  localparam logic [19:0] WORD_B = 20'h000C0;
  localparam logic [19:0] ADDR_C = 20'h001C4;
  localparam logic [19:0] ADDR_X = 20'h00140;

  // Bus responder: acks every request on its second sampled cycle and logs it.
  bit          resp_en = 1'b1;
  int          wait_cnt = 0;
  int          n_tx = 0;
  int          busreq_cycles = 0;
  logic [1:0]  log_cmd [$];
  logic [19:0] log_addr [$];
  logic [31:0] log_dout [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      BusAck   = 1'b0;
      wait_cnt = 0;
    end else begin
      if (BusReq) busreq_cycles++;
      if (BusAck) BusAck = 1'b0;
      else if (BusReq && resp_en) begin
        wait_cnt++;
        if (wait_cnt >= 2) begin
          BusAck   = 1'b1;
          wait_cnt = 0;
          log_cmd.push_back(BusCmd);
          log_addr.push_back(BusAddr);
          log_dout.push_back(DataOut);
          n_tx++;
        end
      end
    end
  end

  task automatic issue(input logic rd, input logic wr, input logic [19:0] a,
                       input logic [31:0] wd, output int lat);
    READ = rd; WRITE = wr; address = a; DataFromProc = wd; lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!Ready && lat < 60);
    if (!Ready) lat = -1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (Ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", Ready); end
    checks++; if (BusReq !== 1'b0) begin errors++; $display("FAIL reset_busreq: got %b want 0", BusReq); end
    checks++; if (BusCmd !== 2'd0) begin errors++; $display("FAIL reset_buscmd: got %0d want 0", BusCmd); end
    checks++; if (BusAddr !== 20'h0) begin errors++; $display("FAIL reset_busaddr: got %h want 0", BusAddr); end
    checks++; if (DataOut !== 32'h0) begin errors++; $display("FAIL reset_dataout: got %h want 0", DataOut); end
    checks++; if (DataToProc !== 32'h0) begin errors++; $display("FAIL reset_datatoproc: got %h want 0", DataToProc); end
    checks++; if (SharedOut !== 1'b0) begin errors++; $display("FAIL reset_sharedout: got %b want 0", SharedOut); end
    checks++; if (Flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", Flush); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_miss_shared();
    int lat, base;
    base = n_tx; Shared = 1'b1; DataIn = 32'habcdef12;
    issue(1'b1, 1'b0, ADDR_A, 32'h0, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rdmiss_latency: got %0d want 3", lat); end
    checks++; if (DataToProc !== 32'habcdef12) begin errors++; $display("FAIL rdmiss_data: got %h want abcdef12", DataToProc); end
    checks++; if (n_tx !== base + 1) begin errors++; $display("FAIL rdmiss_txcount: got %0d want %0d", n_tx - base, 1); end
    if (n_tx > base) begin
      checks++; if (log_cmd[base] !== 2'd0) begin errors++; $display("FAIL rdmiss_cmd: got %0d want 0", log_cmd[base]); end
      checks++; if (log_addr[base] !== WORD_A) begin errors++; $display("FAIL rdmiss_addr: got %h want %h", log_addr[base], WORD_A); end
    end
    @(negedge clk);
    checks++; if (Ready !== 1'b0) begin errors++; $display("FAIL rdmiss_ready_pulse: got %b want 0", Ready); end
    Shared = 1'b0;
  endtask

  task automatic test_read_hit();
    int lat, base, bq;
    base = n_tx; bq = busreq_cycles;
    issue(1'b1, 1'b0, ADDR_A, 32'h0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL rdhit_latency: got %0d want 1", lat); end
    checks++; if (DataToProc !== 32'habcdef12) begin errors++; $display("FAIL rdhit_data: got %h want abcdef12", DataToProc); end
    @(negedge clk);
    checks++; if (Ready !== 1'b0) begin errors++; $display("FAIL rdhit_ready_pulse: got %b want 0", Ready); end
    checks++; if (busreq_cycles !== bq || n_tx !== base) begin errors++; $display("FAIL rdhit_no_bus: got %0d busreq cycles want 0", busreq_cycles - bq); end
  endtask

  task automatic test_write_upgrade();
    int lat, base, bq;
    base = n_tx;
    issue(1'b0, 1'b1, ADDR_A, 32'h12345678, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL upgr_latency: got %0d want 3", lat); end
    checks++; if (n_tx !== base + 1) begin errors++; $display("FAIL upgr_txcount: got %0d want 1", n_tx - base); end
    if (n_tx > base) begin
      checks++; if (log_cmd[base] !== 2'd2) begin errors++; $display("FAIL upgr_cmd: got %0d want 2", log_cmd[base]); end
      checks++; if (log_addr[base] !== WORD_A) begin errors++; $display("FAIL upgr_addr: got %h want %h", log_addr[base], WORD_A); end
    end
    @(negedge clk);
    base = n_tx; bq = busreq_cycles;
    issue(1'b1, 1'b0, ADDR_A, 32'h0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL upgr_readback_latency: got %0d want 1", lat); end
    checks++; if (DataToProc !== 32'h12345678) begin errors++; $display("FAIL upgr_readback_data: got %h want 12345678", DataToProc); end
    checks++; if (busreq_cycles !== bq) begin errors++; $display("FAIL upgr_readback_no_bus: got %0d busreq cycles want 0", busreq_cycles - bq); end
    @(negedge clk);
  endtask

  task automatic test_evict_writeback();
    int lat, base;
    base = n_tx; Shared = 1'b0; DataIn = 32'h0badf00d;
    issue(1'b1, 1'b0, ADDR_B, 32'h0, lat);
    checks++; if (DataToProc !== 32'h0badf00d) begin errors++; $display("FAIL evict_data: got %h want 0badf00d", DataToProc); end
    checks++; if (n_tx !== base + 2) begin errors++; $display("FAIL evict_txcount: got %0d want 2", n_tx - base); end
    if (n_tx > base + 1) begin
      checks++; if (log_cmd[base] !== 2'd3) begin errors++; $display("FAIL evict_wb_cmd: got %0d want 3", log_cmd[base]); end
      checks++; if (log_addr[base] !== WORD_A) begin errors++; $display("FAIL evict_wb_addr: got %h want %h", log_addr[base], WORD_A); end
      checks++; if (log_dout[base] !== 32'h12345678) begin errors++; $display("FAIL evict_wb_data: got %h want 12345678", log_dout[base]); end
      checks++; if (log_cmd[base+1] !== 2'd0) begin errors++; $display("FAIL evict_fill_cmd: got %0d want 0", log_cmd[base+1]); end
      checks++; if (log_addr[base+1] !== WORD_B) begin errors++; $display("FAIL evict_fill_addr: got %h want %h", log_addr[base+1], WORD_B); end
    end
    @(negedge clk);
    // Line should be Exclusive: a write hits silently.
    base = n_tx;
    issue(1'b0, 1'b1, ADDR_B, 32'hcafe0001, lat);
    checks++; if (lat !== 1 || n_tx !== base) begin errors++; $display("FAIL excl_write_silent: got latency %0d tx %0d want latency 1 tx 0", lat, n_tx - base); end
    @(negedge clk);
  endtask

  task automatic test_snoop();
    int lat, base;
    SnoopValid = 1'b1; SnoopCmd = 2'd0; SnoopAddr = ADDR_X;
    #1;
    checks++; if (SharedOut !== 1'b0) begin errors++; $display("FAIL snoop_tag_miss: got %b want 0", SharedOut); end
    @(negedge clk);
    SnoopCmd = 2'd1; SnoopAddr = ADDR_B | 20'h2;
    #1;
    checks++; if (SharedOut !== 1'b1) begin errors++; $display("FAIL snoop_rdx_shared: got %b want 1", SharedOut); end
    checks++; if (Flush !== 1'b1) begin errors++; $display("FAIL snoop_rdx_flush: got %b want 1", Flush); end
    checks++; if (DataOut !== 32'hcafe0001) begin errors++; $display("FAIL snoop_rdx_data: got %h want cafe0001", DataOut); end
    @(negedge clk);
    SnoopValid = 1'b0;
    #1;
    checks++; if (SharedOut !== 1'b0 || Flush !== 1'b0) begin errors++; $display("FAIL snoop_release: got shared %b flush %b want 0 0", SharedOut, Flush); end
    @(negedge clk);
    base = n_tx; Shared = 1'b0; DataIn = 32'h11112222;
    issue(1'b1, 1'b0, ADDR_B, 32'h0, lat);
    checks++; if (n_tx !== base + 1) begin errors++; $display("FAIL snoop_inval_miss_tx: got %0d want 1", n_tx - base); end
    if (n_tx > base) begin
      checks++; if (log_cmd[base] !== 2'd0) begin errors++; $display("FAIL snoop_inval_miss_cmd: got %0d want 0", log_cmd[base]); end
    end
    checks++; if (DataToProc !== 32'h11112222) begin errors++; $display("FAIL snoop_inval_miss_data: got %h want 11112222", DataToProc); end
    @(negedge clk);
    // Exclusive line snooped by BusRd: Shared reply, no flush, then a write needs BusUpgr.
    SnoopValid = 1'b1; SnoopCmd = 2'd0; SnoopAddr = ADDR_B;
    #1;
    checks++; if (SharedOut !== 1'b1 || Flush !== 1'b0) begin errors++; $display("FAIL snoop_rd_excl: got shared %b flush %b want 1 0", SharedOut, Flush); end
    @(negedge clk);
    SnoopValid = 1'b0;
    @(negedge clk);
    base = n_tx;
    issue(1'b0, 1'b1, ADDR_B, 32'h5a5a5a5a, lat);
    checks++; if (n_tx !== base + 1) begin errors++; $display("FAIL snoop_rd_then_write_tx: got %0d want 1", n_tx - base); end
    if (n_tx > base) begin
      checks++; if (log_cmd[base] !== 2'd2) begin errors++; $display("FAIL snoop_rd_then_write_cmd: got %0d want 2", log_cmd[base]); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_during_fill();
    int n, lat, base;
    resp_en = 1'b0;
    READ = 1'b1; address = ADDR_C;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!BusReq && n < 20);
    checks++; if (BusReq !== 1'b1) begin errors++; $display("FAIL rstfill_busreq_up: got %b want 1", BusReq); end
    checks++; if (BusCmd !== 2'd0 || BusAddr !== 20'h001C4) begin errors++; $display("FAIL rstfill_req: got cmd %0d addr %h want 0 001c4", BusCmd, BusAddr); end
    rst_n = 1'b0;
    #1;
    checks++; if (BusReq !== 1'b0) begin errors++; $display("FAIL rstfill_busreq_drop: got %b want 0", BusReq); end
    READ = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++; if (Ready !== 1'b0) begin errors++; $display("FAIL rstfill_no_ready: got %b want 0", Ready); end
    end
    rst_n = 1'b1; resp_en = 1'b1;
    @(negedge clk);
    // Line B was Modified before reset; now it must miss without a writeback.
    base = n_tx; Shared = 1'b0; DataIn = 32'h77778888;
    issue(1'b1, 1'b0, ADDR_B, 32'h0, lat);
    checks++; if (n_tx !== base + 1) begin errors++; $display("FAIL rstfill_miss_tx: got %0d want 1", n_tx - base); end
    if (n_tx > base) begin
      checks++; if (log_cmd[base] !== 2'd0) begin errors++; $display("FAIL rstfill_miss_cmd: got %0d want 0", log_cmd[base]); end
    end
    checks++; if (DataToProc !== 32'h77778888) begin errors++; $display("FAIL rstfill_miss_data: got %h want 77778888", DataToProc); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read_miss_shared();
    test_read_hit();
    test_write_upgrade();
    test_evict_writeback();
    test_snoop();
    test_reset_during_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
